// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the control unit and the shared multiply/divide engine.
// The requester drives start/op/a/b; the engine returns busy/done/div0 and the hi/lo result.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div0, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// Shared radix-2 sequential engine for signed/unsigned multiply and divide.
// Operates on operand magnitudes for WIDTH steps, then applies result signs in a single fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic            clock,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, FIN = 2'd3} state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               is_div_r, neg_res_r, neg_rem_r;
  logic [WIDTH-1:0]   mag_a_r, mag_b_r, rem_r, hi_r, lo_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               busy_r, done_r, div0_r;

  logic               op_signed_s, op_div_s, b_zero_s, a_neg_s, b_neg_s, zero_div_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s, quo_raw_s, quo_fix_s, rem_fix_s;
  logic [WIDTH:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;

  assign op_signed_s = ~bus.op[0];
  assign op_div_s    = bus.op[1];
  assign b_zero_s    = (bus.b == {WIDTH{1'b0}});
  assign a_neg_s     = op_signed_s & bus.a[WIDTH-1];
  assign b_neg_s     = op_signed_s & bus.b[WIDTH-1];
  assign a_mag_s     = a_neg_s ? -bus.a : bus.a;
  assign b_mag_s     = b_neg_s ? -bus.b : bus.b;
  assign zero_div_s  = (state_r == IDLE) & bus.start & op_div_s & b_zero_s;

  // One radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                       (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
  assign div_shift_s = {rem_r, acc_r[WIDTH-1]};
  assign div_diff_s  = div_shift_s - {1'b0, mag_b_r};

  // Sign fix-up; most-negative / -1 falls out naturally as lo = most-negative, hi = 0
  assign prod_s    = neg_res_r ? -acc_r : acc_r;
  assign quo_raw_s = acc_r[WIDTH-1:0];
  assign quo_fix_s = neg_res_r ? -quo_raw_s : quo_raw_s;
  assign rem_fix_s = neg_rem_r ? -rem_r : rem_r;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          if (op_div_s && b_zero_s) begin
            state_nxt_s = FIN;
          end else begin
            state_nxt_s = CALC;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = FIX;
        end else begin
          state_nxt_s = CALC;
        end
      end
      FIX:     state_nxt_s = FIN;
      FIN:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand capture, iteration and result write-back
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r     <= {CNT_W{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      mag_a_r   <= {WIDTH{1'b0}};
      mag_b_r   <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            cnt_r     <= CNT_W'(WIDTH);
            is_div_r  <= op_div_s;
            neg_res_r <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            mag_a_r   <= a_mag_s;
            mag_b_r   <= b_mag_s;
            rem_r     <= {WIDTH{1'b0}};
            acc_r     <= {{WIDTH{1'b0}}, (op_div_s ? a_mag_s : b_mag_s)};
          end
        end
        CALC: begin
          cnt_r <= cnt_r - CNT_W'(1);
          if (!is_div_r) begin
            acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
          end else if (!div_diff_s[WIDTH]) begin
            rem_r <= div_diff_s[WIDTH-1:0];
            acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b1};
          end else begin
            rem_r <= div_shift_s[WIDTH-1:0];
            acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          if (is_div_r) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
          end else begin
            {hi_r, lo_r} <= prod_s;
          end
        end
        FIN:     cnt_r <= {CNT_W{1'b0}};
        default: cnt_r <= {CNT_W{1'b0}};
      endcase
    end
  end

  // Registered handshake flags, derived from the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      div0_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s == CALC) || (state_nxt_s == FIX);
      done_r <= (state_nxt_s == FIN);
      div0_r <= zero_div_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.div0 = div0_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: a vector table, seeded random operands against an
// arithmetic model, and hand sequences for mid-operation start and reset.
module tb_mult_div_unit;
  localparam int W = 32;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    int           lat;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vecs[11];

  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(W)) bus ();
  mult_div_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Arithmetic reference: wide products and SV's truncating signed division
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sp;
    logic [63:0] up;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    e.div0 = 1'b0;
    e.lat  = W + 2;
    case (op)
      2'b00: begin
        sp = 64'(sa) * 64'(sb);
        {e.hi, e.lo} = sp;
      end
      2'b01: begin
        up = {32'h0, a} * {32'h0, b};
        {e.hi, e.lo} = up;
      end
      2'b10: begin
        e.lo = sa / sb;
        e.hi = sa % sb;
      end
      default: begin
        e.lo = a / b;
        e.hi = a % b;
      end
    endcase
    return e;
  endfunction

  // Waits up to a cycle budget for done; optionally pokes a competing start mid-operation
  task automatic wait_done(input int poke_at, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    while (lat < 100 && !seen) begin
      @(negedge clock);
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (poke_at != 0 && lat == poke_at) begin
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'h0000_0064;
        bus.b     = 32'h0000_0064;
      end
      if (poke_at != 0 && lat == poke_at + 1) bus.start = 1'b0;
      seen = bus.done;
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
  endtask

  task automatic check_result(input string tag, input int lat, input bit seen);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_done"}, 64'(seen), 64'(1'b1));
      if (seen) begin
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
        check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
        check({tag, "_div0"}, 64'(bus.div0), 64'(e.div0));
        check({tag, "_busy"}, 64'(bus.busy), 64'(1'b0));
        @(negedge clock);
        check({tag, "_pulse"}, 64'(bus.done), 64'(1'b0));
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e);
    int lat;
    bit seen;
    sb_q.push_back(e);
    drive(op, a, b);
    wait_done(0, lat, seen);
    check_result(tag, lat, seen);
  endtask

  initial begin
    int   lat;
    bit   seen;
    bit   any_done;
    exp_t e;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 34};
    vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[4]  = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 1'b0, 34};
    vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34};
    vecs[6]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[7]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 34};
    vecs[8]  = '{2'b11, 32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 34};
    vecs[9]  = '{2'b11, 32'h0000_0007, 32'h0000_0003, 32'h0000_0001, 32'h0000_0002, 1'b0, 34};
    vecs[10] = '{2'b10, 32'h0000_0005, 32'h0000_0000, 32'h0000_0001, 32'h0000_0002, 1'b1, 1};

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_done", 64'(bus.done), 64'(1'b0));
    check("rst_div0", 64'(bus.div0), 64'(1'b0));
    check("rst_hi", 64'(bus.hi), 64'(0));
    check("rst_lo", 64'(bus.lo), 64'(0));
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      e = '{hi: vecs[i].hi, lo: vecs[i].lo, div0: vecs[i].div0, lat: vecs[i].lat};
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'h0) rb = 32'h0000_0001;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // A competing start five cycles into a multiply must not disturb the first result
    sb_q.push_back('{hi: 32'h0, lo: 32'd42, div0: 1'b0, lat: 34});
    drive(2'b00, 32'd6, 32'd7);
    wait_done(5, lat, seen);
    check_result("busy_ign", lat, seen);

    // Reset in the tenth CALC cycle aborts the operation with no done pulse
    drive(2'b01, 32'd3, 32'd5);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_busy", 64'(bus.busy), 64'(1'b0));
    check("mid_rst_done", 64'(bus.done), 64'(1'b0));
    check("mid_rst_hi", 64'(bus.hi), 64'(0));
    check("mid_rst_lo", 64'(bus.lo), 64'(0));
    reset    = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.done) any_done = 1'b1;
    end
    check("mid_rst_no_done", 64'(any_done), 64'(1'b0));
    run_op("post_rst", 2'b01, 32'd3, 32'd5, '{hi: 32'h0, lo: 32'd15, div0: 1'b0, lat: 34});

    check("sb_empty", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
